// File: rtl/ifu.sv
// Instruction fetch unit: fetches one word per instruction, holds it for the decoder,
// and steps the PC (sequential, beq or j) when the decoder acknowledges it.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic [1:0]  npc_jmp,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] retired
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] npc;

    // The PC stays word aligned because every npc source is aligned to a multiple of 4.
    always_comb begin
        pcPlus4      = pc_q + 32'd4;
        branchOffset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        npc          = pcPlus4;
        case (npc_jmp)
            2'b01:   npc = zero ? (pcPlus4 + branchOffset) : pcPlus4;
            2'b10:   npc = {pcPlus4[31:28], instr_q[25:0], 2'b00};
            default: npc = pcPlus4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    pc_d      = npc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Reset wins over any handshake in the same cycle, dropping a pending instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run against
// a transaction-level model of fetch/issue/retire.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_ack;
    logic [1:0]  npc_jmp;
    logic        zero;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, retired;

    logic        wImemReq, wInstrValid;
    logic [31:0] wImemAddr, wInstr, wPc, wRetired;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: whether an instruction is being held, and the architectural values.
    logic        mValid;
    logic [31:0] mPc, mInstr, mRetired;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
        .npc_jmp(npc_jmp), .zero(zero),
        .pc(pc), .retired(retired)
    );

    ifu #(.RESET_PC(WRAP_PC)) dutWrap (
        .clk(clk), .reset(reset),
        .imem_req(wImemReq), .imem_addr(wImemAddr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(wInstr), .instr_valid(wInstrValid), .instr_ack(instr_ack),
        .npc_jmp(npc_jmp), .zero(zero),
        .pc(wPc), .retired(wRetired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] modelNpc(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [1:0] jmp, input logic z);
        logic [31:0] seq;
        logic [15:0] imm;
        seq = p + 32'd4;
        imm = ins[15:0];
        if (jmp == 2'b01 && z)
            return seq + 32'($signed(imm)) * 32'd4;
        if (jmp == 2'b10)
            return (seq & 32'hF000_0000) + {6'd0, ins[25:0]} * 32'd4;
        return seq;
    endfunction

    task automatic applyStimulus(input logic r, input logic rdy, input logic [31:0] rd,
                                 input logic ak, input logic [1:0] jmp, input logic z);
        reset      = r;
        imem_ready = rdy;
        imem_rdata = rd;
        instr_ack  = ak;
        npc_jmp    = jmp;
        zero       = z;
        if (r) begin
            mValid = 1'b0; mPc = RESET_PC; mInstr = 32'd0; mRetired = 32'd0;
        end else if (!mValid) begin
            if (rdy) begin
                mInstr = rd; mValid = 1'b1;
            end
        end else if (ak) begin
            mPc = modelNpc(mPc, mInstr, jmp, z);
            mRetired = mRetired + 32'd1;
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b1);
        nChecks++;
        if (pc !== RESET_PC || retired !== 32'd0 || instr !== 32'd0) begin
            nErrors++;
            $display("[TB] FAIL reset_regs: pc=%h retired=%h instr=%h, need %h 0 0", pc, retired, instr, RESET_PC);
        end
        nChecks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            nErrors++;
            $display("[TB] FAIL reset_fetch: valid=%b req=%b addr=%h, need 0 1 %h", instr_valid, imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b0);
        nChecks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'd0 || pc !== 32'h3000) begin
            nErrors++;
            $display("[TB] FAIL seq_issue: valid=%b req=%b instr=%h pc=%h, need 1 0 0 3000", instr_valid, imem_req, instr, pc);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b00, 1'b0);
        nChecks++;
        if (pc !== 32'h3004 || retired !== 32'd1 || instr_valid !== 1'b0 || imem_addr !== 32'h3004) begin
            nErrors++;
            $display("[TB] FAIL seq_retire: pc=%h retired=%0d valid=%b addr=%h, need 3004 1 0 3004", pc, retired, instr_valid, imem_addr);
        end
    endtask

    task automatic test_beq();
        applyStimulus(1'b0, 1'b1, 32'h1000_FFFF, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b01, 1'b1);
        nChecks++;
        if (pc !== 32'h3004 || retired !== 32'd2) begin
            nErrors++;
            $display("[TB] FAIL beq_taken: pc=%h retired=%0d, need 3004 2", pc, retired);
        end
        applyStimulus(1'b0, 1'b1, 32'h1000_FFFF, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b01, 1'b0);
        nChecks++;
        if (pc !== 32'h3008 || retired !== 32'd3) begin
            nErrors++;
            $display("[TB] FAIL beq_not_taken: pc=%h retired=%0d, need 3008 3", pc, retired);
        end
    endtask

    task automatic test_jump();
        applyStimulus(1'b0, 1'b1, 32'h0800_0C10, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b10, 1'b0);
        nChecks++;
        if (pc !== 32'h0000_3040 || retired !== 32'd4) begin
            nErrors++;
            $display("[TB] FAIL jump: pc=%h retired=%0d, need 00003040 4", pc, retired);
        end
    endtask

    task automatic test_fetch_stall();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, $urandom, i[0], 2'($urandom), 1'($urandom));
            nChecks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h3040 || instr_valid !== 1'b0 ||
                pc !== 32'h3040 || retired !== 32'd4) begin
                nErrors++;
                $display("[TB] FAIL fetch_stall[%0d]: req=%b addr=%h valid=%b pc=%h retired=%0d, need 1 3040 0 3040 4",
                         i, imem_req, imem_addr, instr_valid, pc, retired);
            end
        end
    endtask

    task automatic test_issue_stall();
        logic [31:0] word;
        word = $urandom;
        applyStimulus(1'b0, 1'b1, word, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'($urandom), $urandom, 1'b0, 2'($urandom), 1'($urandom));
            nChecks++;
            if (instr !== word || pc !== 32'h3040 || imem_req !== 1'b0 ||
                instr_valid !== 1'b1 || retired !== 32'd4) begin
                nErrors++;
                $display("[TB] FAIL issue_stall[%0d]: instr=%h pc=%h req=%b valid=%b retired=%0d, need %h 3040 0 1 4",
                         i, instr, pc, imem_req, instr_valid, retired, word);
            end
        end
    endtask

    task automatic test_reset_in_issue();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 2'b10, 1'b1);
        nChecks++;
        if (pc !== RESET_PC || retired !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL reset_in_issue: pc=%h retired=%0d valid=%b req=%b, need %h 0 0 1",
                     pc, retired, instr_valid, imem_req, RESET_PC);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b00, 1'b0);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || retired !== 32'd0) begin
            nErrors++;
            $display("[TB] FAIL after_release: req=%b addr=%h valid=%b retired=%0d, need 1 %h 0 0",
                     imem_req, imem_addr, instr_valid, retired, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 2'b00, 1'b0);
        nChecks++;
        if (wPc !== WRAP_PC || wImemAddr !== WRAP_PC) begin
            nErrors++;
            $display("[TB] FAIL wrap_reset: pc=%h addr=%h, need %h", wPc, wImemAddr, WRAP_PC);
        end
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 2'b00, 1'b0);
        nChecks++;
        if (wPc !== 32'd0 || wRetired !== 32'd1) begin
            nErrors++;
            $display("[TB] FAIL wrap_seq: pc=%h retired=%0d, need 00000000 1", wPc, wRetired);
        end
    endtask

    task automatic test_random();
        logic [31:0] word;
        for (int i = 0; i < 600; i++) begin
            word = $urandom;
            if ($urandom_range(0, 3) == 0)
                word = {6'b000100, word[25:16], 16'($signed(16'($urandom_range(0, 40))) - 16'sd20)};
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), word, 1'($urandom),
                          2'($urandom), 1'($urandom));
            nChecks++;
            if (instr_valid !== mValid || imem_req !== !mValid || pc !== mPc || instr !== mInstr ||
                retired !== mRetired || (!mValid && imem_addr !== mPc) || pc[1:0] !== 2'b00) begin
                nErrors++;
                $display("[TB] FAIL random[%0d]: valid=%b pc=%h instr=%h retired=%0d addr=%h, need valid=%b pc=%h instr=%h retired=%0d",
                         i, instr_valid, pc, instr, retired, imem_addr, mValid, mPc, mInstr, mRetired);
            end
        end
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0;
        instr_ack = 1'b0; npc_jmp = 2'b00; zero = 1'b0;
        mValid = 1'b0; mPc = RESET_PC; mInstr = 32'd0; mRetired = 32'd0;
        test_reset();
        test_sequential();
        test_beq();
        test_jump();
        test_fetch_stall();
        test_issue_stall();
        test_reset_in_issue();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h0000_3000, which is the first instruction address after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have the port imem_addr, output, 32 bits: byte address of the requested word.
REQ-006 The block SHALL have the port imem_ready, input, 1 bit: memory returns imem_rdata this cycle.
REQ-007 The block SHALL have the port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 The block SHALL have the port instr, output, 32 bits: instruction word presented to the control decoder.
REQ-009 The block SHALL have the port instr_valid, output, 1 bit: instr holds a valid, unconsumed instruction.
REQ-010 The block SHALL have the port instr_ack, input, 1 bit: downstream has consumed instr and is supplying npc_jmp/zero this cycle.
REQ-011 The block SHALL have the port npc_jmp, input, 2 bits: next-PC select from the decoder (00 sequential, 01 beq, 10 j, 11 reserved).
REQ-012 The block SHALL have the port zero, input, 1 bit: ALU equality flag for beq.
REQ-013 The block SHALL have the port pc, output, 32 bits: address of the instruction currently in instr.
REQ-014 The block SHALL have the port retired, output, 32 bits: count of acknowledged instructions.

Function
REQ-015 The block SHALL implement a two-state FSM, FETCH and ISSUE.
REQ-016 In FETCH, imem_req SHALL be 1, imem_addr SHALL equal pc, and instr_valid SHALL be 0.
REQ-017 In FETCH with imem_ready=1, the block SHALL register imem_rdata into instr at that edge and move to ISSUE.
REQ-018 In FETCH with imem_ready=0, the block SHALL stay in FETCH with imem_addr held stable, for an unbounded wait.
REQ-019 In ISSUE, imem_req SHALL be 0 and instr_valid SHALL be 1, with instr and pc held stable until instr_ack=1.
REQ-020 In ISSUE with instr_ack=1, pc SHALL load npc, retired SHALL increment by 1, and the FSM SHALL move to FETCH at that edge.
REQ-021 npc SHALL be computed combinationally from pc, instr, npc_jmp and zero as follows:
- 00 or 11: pc+4.
- 01 with zero=1: pc+4 + (sign-extended instr[15:0] << 2).
- 01 with zero=0: pc+4.
- 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-022 All address arithmetic SHALL be 32-bit modulo 2^32 (wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000).
REQ-023 pc[1:0] SHALL always be 2'b00.
REQ-024 imem_ready SHALL be ignored outside FETCH.
REQ-025 instr_ack SHALL be ignored outside ISSUE (no pc change, no count).
REQ-026 npc_jmp and zero SHALL be sampled only on the acknowledging edge.
REQ-027 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 Best-case throughput SHALL be one instruction per 2 cycles (imem_ready and instr_ack both asserted on first opportunity).
REQ-029 Latency from FETCH entry with imem_ready=1 to instr_valid=1 SHALL be 1 cycle.

Reset
REQ-030 While reset=1 at a rising edge, the block SHALL set state=FETCH, pc=RESET_PC, instr=0, retired=0; reset SHALL take priority over imem_ready and instr_ack in the same cycle.
REQ-031 In the first cycle after reset deassertion, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-fetch or mid-issue SHALL abandon the pending instruction (no retire, instr_valid=0 next cycle).

Verification
REQ-033 Reset then imem_ready=1 with rdata=32'h0000_0000, ack with npc_jmp=00 -> instr_valid one cycle later; pc 3000 -> 3004; retired=1.
REQ-034 pc=3004, instr=32'h1000_FFFF (beq, imm -1), npc_jmp=01: zero=1 -> pc=3004; zero=0 -> pc=3008.
REQ-035 pc=3008, instr=32'h0800_0C10 (j), npc_jmp=10 -> pc=32'h0000_3040.
REQ-036 imem_ready held 0 for 5 cycles -> imem_req=1, imem_addr unchanged, instr_valid=0 throughout; instr_ack pulses during this time have no effect.
REQ-037 instr_ack held 0 for 4 cycles in ISSUE -> instr/pc stable, imem_req=0, retired unchanged; varying imem_ready has no effect.
REQ-038 Reset asserted in ISSUE coincident with instr_ack=1 -> pc=RESET_PC, retired=0, instr_valid=0, imem_req=1 after release.
